// File: rtl/pwm_gen_pkg.sv
// rtl/pwm_gen_pkg.sv - shared defaults and counter type for the PWM generator
package pwm_gen_pkg;

    localparam int PWM_WIDTH_DEF    = 4;
    localparam int PWM_DEADTIME_DEF = 1;

    typedef logic [PWM_WIDTH_DEF-1:0] cnt_t;

endpackage

// File: rtl/pwm_gen_deadtime.sv
// rtl/pwm_gen_deadtime.sv - complementary output pair with dead-time insertion
module pwm_gen_deadtime #(
    parameter int WIDTH    = 4,
    parameter int DEADTIME = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic pwm_raw,
    output logic pwm,
    output logic pwm_n
);

    localparam logic [WIDTH-1:0] DT_LOAD = WIDTH'(DEADTIME);

    logic             raw_q;
    logic [WIDTH-1:0] dt_q;
    logic [WIDTH-1:0] dt_nxt;
    logic             settled;

    // Any raw edge (re)starts the dead window, so a pulse shorter than the
    // window never reaches either output.
    always_comb begin
        dt_nxt = '0;
        if (pwm_raw != raw_q) begin
            dt_nxt = DT_LOAD;
        end else if (dt_q != '0) begin
            dt_nxt = dt_q - 1'b1;
        end
        settled = (dt_nxt == '0);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            raw_q <= 1'b0;
            dt_q  <= '0;
            pwm   <= 1'b0;
            pwm_n <= 1'b0;
        end else begin
            raw_q <= pwm_raw;
            dt_q  <= dt_nxt;
            pwm   <= pwm_raw & settled;
            pwm_n <= ~pwm_raw & settled;
        end
    end

endmodule

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - period counter PWM with shadowed duty; PWM_GEN_COMP_EN adds o_pwm_n with dead-time
module pwm_gen
    import pwm_gen_pkg::*;
#(
    parameter int WIDTH    = $bits(cnt_t),
    parameter int DEADTIME = PWM_DEADTIME_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_duty,
    input  logic             i_en,
    output logic             o_pwm,
`ifdef PWM_GEN_COMP_EN
    output logic             o_pwm_n,
`endif
    output logic             o_period
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] duty_q;
    logic [WIDTH-1:0] duty_nxt;
    logic             last;
    logic             pwm_nxt;

    // The output flop is fed from next-state values so o_pwm lines up with
    // the cycle in which cnt holds the value it is compared against.
    always_comb begin
        last     = (cnt == CNT_MAX);
        cnt_nxt  = cnt;
        duty_nxt = duty_q;
        if (i_en) begin
            cnt_nxt = cnt + 1'b1;
            if (last) begin
                duty_nxt = i_duty;
            end
        end
        pwm_nxt = i_en && (cnt_nxt < duty_nxt);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt    <= '0;
            duty_q <= '0;
        end else begin
            cnt    <= cnt_nxt;
            duty_q <= duty_nxt;
        end
    end

    assign o_period = i_en & last;

`ifdef PWM_GEN_COMP_EN
    pwm_gen_deadtime #(
        .WIDTH    (WIDTH),
        .DEADTIME (DEADTIME)
    ) u_deadtime (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .pwm_raw (pwm_nxt),
        .pwm     (o_pwm),
        .pwm_n   (o_pwm_n)
    );
`else
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_pwm <= 1'b0;
        end else begin
            o_pwm <= pwm_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_gen.sv
// tb/tb_pwm_gen.sv - directed self-checking bench for pwm_gen
module tb_pwm_gen;

    localparam int W = 4;
    localparam int N = 16;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_en;
    logic [W-1:0] i_duty;
    logic         o_pwm;
    logic         o_period;
`ifdef PWM_GEN_COMP_EN
    logic         o_pwm_n;
`endif

    int checks   = 0;
    int failures = 0;

    pwm_gen #(
        .WIDTH    (W),
        .DEADTIME (1)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_duty   (i_duty),
        .i_en     (i_en),
        .o_pwm    (o_pwm),
`ifdef PWM_GEN_COMP_EN
        .o_pwm_n  (o_pwm_n),
`endif
        .o_period (o_period)
    );

    always #10 i_clk = ~i_clk;

    task automatic tick;
        @(negedge i_clk);
    endtask

    // Checks one full period starting at the cnt=0 sample; requests next_duty mid-period.
    task automatic check_period(input int d, input int next_duty, input string nm);
        logic exp_pwm;
        logic exp_per;
        for (int i = 0; i < N; i++) begin
            exp_pwm = (i < d);
            exp_per = (i == N - 1);
`ifdef PWM_GEN_COMP_EN
            checks++;
            if ((o_pwm & o_pwm_n) !== 1'b0) begin
                failures++;
                $display("FAIL %s overlap i=%0d pwm=%b pwm_n=%b required not both 1", nm, i, o_pwm, o_pwm_n);
            end
`else
            checks++;
            if (o_pwm !== exp_pwm) begin
                failures++;
                $display("FAIL %s pwm i=%0d got=%b exp=%b", nm, i, o_pwm, exp_pwm);
            end
`endif
            checks++;
            if (o_period !== exp_per) begin
                failures++;
                $display("FAIL %s period i=%0d got=%b exp=%b", nm, i, o_period, exp_per);
            end
            if (i == 7) i_duty = W'(next_duty);
            tick();
        end
    endtask

    task automatic test_reset;
        i_rst  = 1'b1;
        i_en   = 1'b1;
        i_duty = 4'd4;
        #5;
        checks++;
        if (o_pwm !== 1'b0) begin
            failures++;
            $display("FAIL reset_pwm got=%b exp=0", o_pwm);
        end
        checks++;
        if (o_period !== 1'b0) begin
            failures++;
            $display("FAIL reset_period got=%b exp=0", o_period);
        end
`ifdef PWM_GEN_COMP_EN
        checks++;
        if (o_pwm_n !== 1'b0) begin
            failures++;
            $display("FAIL reset_pwm_n got=%b exp=0", o_pwm_n);
        end
`endif
        tick();
        checks++;
        if (o_pwm !== 1'b0) begin
            failures++;
            $display("FAIL reset_pwm_edge got=%b exp=0", o_pwm);
        end
        i_rst = 1'b0;
    endtask

    task automatic test_basic;
        check_period(0, 4, "first_low");
        check_period(4, 4, "duty4_a");
        check_period(4, 4, "duty4_b");
    endtask

    task automatic test_duty_change;
        check_period(4, 8, "chg_4_to_8");
        check_period(8, 12, "chg_8_to_12");
        check_period(12, 12, "duty12");
    endtask

    task automatic test_extremes;
        check_period(12, 0, "chg_12_to_0");
        check_period(0, 0, "duty0_a");
        check_period(0, 15, "duty0_b");
        check_period(15, 15, "duty15_a");
        check_period(15, 8, "duty15_b");
    endtask

    task automatic test_pause;
        logic exp_pwm;
        for (int i = 0; i < 5; i++) begin
`ifdef PWM_GEN_COMP_EN
            exp_pwm = (i >= 1) && (i < 8);
`else
            exp_pwm = (i < 8);
`endif
            checks++;
            if (o_pwm !== exp_pwm) begin
                failures++;
                $display("FAIL pause_pre i=%0d got=%b exp=%b", i, o_pwm, exp_pwm);
            end
            if (i < 4) tick();
        end
        i_en = 1'b0;
        for (int p = 0; p < 5; p++) begin
            tick();
            checks++;
            if (o_pwm !== 1'b0) begin
                failures++;
                $display("FAIL pause_pwm p=%0d got=%b exp=0", p, o_pwm);
            end
            checks++;
            if (o_period !== 1'b0) begin
                failures++;
                $display("FAIL pause_period p=%0d got=%b exp=0", p, o_period);
            end
        end
        i_en = 1'b1;
        tick();
        for (int i = 5; i < N; i++) begin
`ifdef PWM_GEN_COMP_EN
            exp_pwm = (i >= 6) && (i < 8);
`else
            exp_pwm = (i < 8);
`endif
            checks++;
            if (o_pwm !== exp_pwm) begin
                failures++;
                $display("FAIL pause_post i=%0d got=%b exp=%b", i, o_pwm, exp_pwm);
            end
            checks++;
            if (o_period !== (i == N - 1)) begin
                failures++;
                $display("FAIL pause_period_post i=%0d got=%b exp=%b", i, o_period, (i == N - 1));
            end
            tick();
        end
    endtask

    task automatic test_reset_mid;
        check_period(8, 12, "chg_8_to_12_pre_rst");
        for (int i = 0; i < 7; i++) tick();
`ifndef PWM_GEN_COMP_EN
        checks++;
        if (o_pwm !== 1'b1) begin
            failures++;
            $display("FAIL pre_rst_pwm got=%b exp=1", o_pwm);
        end
`endif
        #2;
        i_rst = 1'b1;
        #1;
        checks++;
        if (o_pwm !== 1'b0) begin
            failures++;
            $display("FAIL async_rst_pwm got=%b exp=0", o_pwm);
        end
        checks++;
        if (o_period !== 1'b0) begin
            failures++;
            $display("FAIL async_rst_period got=%b exp=0", o_period);
        end
        tick();
        i_rst = 1'b0;
        check_period(0, 12, "post_rst_low");
        check_period(12, 12, "post_rst_d12_a");
        check_period(12, 12, "post_rst_d12_b");
    endtask

`ifdef PWM_GEN_COMP_EN
    task automatic test_comp;
        int n_high;
        logic exp_p;
        logic exp_n;
        check_period(12, 8, "comp_chg");
        check_period(8, 8, "comp_settle");
        n_high = 0;
        for (int i = 0; i < N; i++) begin
            exp_p = (i >= 1) && (i < 8);
            exp_n = (i >= 9);
            checks++;
            if (o_pwm !== exp_p) begin
                failures++;
                $display("FAIL comp_pwm i=%0d got=%b exp=%b", i, o_pwm, exp_p);
            end
            checks++;
            if (o_pwm_n !== exp_n) begin
                failures++;
                $display("FAIL comp_pwm_n i=%0d got=%b exp=%b", i, o_pwm_n, exp_n);
            end
            if (o_pwm_n === 1'b1) n_high++;
            tick();
        end
        checks++;
        if (n_high != 7) begin
            failures++;
            $display("FAIL comp_pwm_n_high got=%0d exp=7", n_high);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_duty_change();
        test_extremes();
        test_pause();
        test_reset_mid();
`ifdef PWM_GEN_COMP_EN
        test_comp();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
